// File: rtl/ror_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ror_arbiter
//
// Lets two requesters share one 16-bit rotate-right unit. The arbiter picks a
// winner round-robin and captures the winner's operand. Left rotates are
// turned into the equivalent right-rotate amount. The result from the shared
// rotator is held on a valid/ready response port. Only one operation is in
// flight at a time, so responses leave in acceptance order.
//
// Handshakes: a transfer happens on any rising edge where valid and ready are
// both 1. A requester holds valid and its fields stable until it sees ready.
// The response holds rsp_valid, rsp_data and rsp_id stable until rsp_ready.
// The arbiter's readys depend combinationally on the request valids. rsp_valid
// does not depend on rsp_ready.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (0 or 1)
//   reqN_data                  operand to rotate
//   reqN_shamt                 rotate amount (bit 4 has no effect)
//   reqN_left                  1 = rotate left, 0 = rotate right
//   rot_ain / rot_shamt        operand and right-rotate amount to the rotator
//   rot_aout                   combinational result from the rotator
//   rsp_valid / rsp_ready      response handshake
//   rsp_data / rsp_id          rotated result and the requester that issued it
//   ops_done                   completed responses, wraps modulo 2**CNT_W
//   dbg_state                  current FSM state (IDLE=0, EXEC=1, HOLD=2)
// -----------------------------------------------------------------------------
module ror_arbiter #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_left,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_left,
  output logic [DATA_W-1:0]  rot_ain,
  output logic [SHAMT_W-1:0] rot_shamt,
  input  logic [DATA_W-1:0]  rot_aout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_id,
  output logic [CNT_W-1:0]   ops_done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q,      state_d;
  logic               last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  cap_data_q,   cap_data_d;
  logic [SHAMT_W-1:0] cap_shamt_q,  cap_shamt_d;
  logic               cap_id_q,     cap_id_d;
  logic               rsp_valid_q,  rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q,   rsp_data_d;
  logic               rsp_id_q,     rsp_id_d;
  logic [CNT_W-1:0]   ops_done_q,   ops_done_d;

  logic               any_valid;
  logic               grant;
  logic [DATA_W-1:0]  sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic               sel_left;
  logic [3:0]         sel_amt;
  logic [3:0]         eff_amt;

  // Arbitration and amount conversion for the requester that would win now.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      // On a tie, the requester that did not win last time wins now.
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
    sel_data  = grant ? req1_data  : req0_data;
    sel_shamt = grant ? req1_shamt : req0_shamt;
    sel_left  = grant ? req1_left  : req0_left;
    // Only the low 4 bits matter for a 16-bit rotate. A left rotate by k is a
    // right rotate by (16 - k) mod 16, which is 0 - k in 4-bit arithmetic.
    sel_amt   = sel_shamt[3:0];
    eff_amt   = sel_left ? (4'd0 - sel_amt) : sel_amt;
  end

  assign req0_ready = (state_q == IDLE) & req0_valid & ~grant;
  assign req1_ready = (state_q == IDLE) & req1_valid &  grant;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cap_data_d   = cap_data_q;
    cap_shamt_d  = cap_shamt_q;
    cap_id_d     = cap_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    ops_done_d   = ops_done_q;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          cap_data_d   = sel_data;
          cap_shamt_d  = {{(SHAMT_W-4){1'b0}}, eff_amt};
          cap_id_d     = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // The rotator is combinational. Its output for the captured operands
        // is ready within this cycle.
        rsp_data_d  = rot_aout;
        rsp_id_d    = cap_id_q;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cap_data_q   <= '0;
      cap_shamt_q  <= '0;
      cap_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cap_data_q   <= cap_data_d;
      cap_shamt_q  <= cap_shamt_d;
      cap_id_q     <= cap_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // The captured registers drive the rotator all the time. Their values only
  // matter during EXEC.
  assign rot_ain   = cap_data_q;
  assign rot_shamt = cap_shamt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign ops_done  = ops_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ror_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ror_arbiter
//
// Bench for ror_arbiter. It models the shared rotator. A transaction-level
// model predicts the expected outputs. A compare process checks the DUT
// against the model on every falling edge. A response scoreboard checks each
// response that is handed over. Directed tasks add hand-computed literal
// expectations.
// -----------------------------------------------------------------------------
module tb_ror_arbiter;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic [4:0]  req0_shamt = '0, req1_shamt = '0;
  logic        req0_left = 1'b0, req1_left = 1'b0;
  logic [15:0] rot_ain;
  logic [4:0]  rot_shamt;
  logic [15:0] rot_aout;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic [7:0]  ops_done;
  logic [1:0]  dbg_state;

  ror_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_left  (req0_left),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_left  (req1_left),
    .rot_ain    (rot_ain),
    .rot_shamt  (rot_shamt),
    .rot_aout   (rot_aout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .ops_done   (ops_done),
    .dbg_state  (dbg_state)
  );

  // Shared rotator: a combinational right rotate by the low 4 amount bits.
  function automatic logic [15:0] ror16(input logic [15:0] a, input logic [4:0] s);
    logic [31:0] t;
    t = {a, a} >> s[3:0];
    return t[15:0];
  endfunction
  assign rot_aout = ror16(rot_ain, rot_shamt);

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endfunction

  // ---------------- behavioural model ----------------
  // The model rotates in the requested direction one bit at a time. It works
  // out the right-rotate amount the rotator should see as (16 - k) mod 16.
  function automatic logic [15:0] rotate_model(input logic [15:0] d, input logic [4:0] s,
                                               input logic left);
    logic [15:0] r;
    int k;
    r = d;
    k = int'(s) % 16;
    for (int i = 0; i < k; i++) r = left ? {r[14:0], r[15]} : {r[0], r[15:1]};
    return r;
  endfunction

  function automatic logic [4:0] right_amount(input logic [4:0] s, input logic left);
    int k;
    k = int'(s) % 16;
    return left ? 5'((16 - k) % 16) : 5'(k);
  endfunction

  int          m_phase = 0;          // 0 waiting for work, 1 rotating, 2 holding result
  logic        m_last  = 1'b1;       // requester that won the last grant
  logic [15:0] m_ain   = '0;
  logic [4:0]  m_amt   = '0;
  logic [15:0] m_res   = '0;
  logic        m_id    = 1'b0;
  logic        m_rv    = 1'b0;
  logic [15:0] m_rd    = '0;
  logic        m_rid   = 1'b0;
  logic [7:0]  m_ops   = '0;
  logic [16:0] exp_q[$];             // {id, data} of each accepted operation

  // The requester the model grants from the current inputs.
  wire        m_w     = (req0_valid && req1_valid) ? !m_last : req1_valid;
  wire [15:0] m_sel_d = m_w ? req1_data  : req0_data;
  wire [4:0]  m_sel_s = m_w ? req1_shamt : req0_shamt;
  wire        m_sel_l = m_w ? req1_left  : req0_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_last  <= 1'b1;
      m_ain   <= '0;
      m_amt   <= '0;
      m_res   <= '0;
      m_id    <= 1'b0;
      m_rv    <= 1'b0;
      m_rd    <= '0;
      m_rid   <= 1'b0;
      m_ops   <= '0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (req0_valid || req1_valid) begin
        m_id    <= m_w;
        m_last  <= m_w;
        m_ain   <= m_sel_d;
        m_amt   <= right_amount(m_sel_s, m_sel_l);
        m_res   <= rotate_model(m_sel_d, m_sel_s, m_sel_l);
        exp_q.push_back({m_w, rotate_model(m_sel_d, m_sel_s, m_sel_l)});
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_rv    <= 1'b1;
      m_rd    <= m_res;
      m_rid   <= m_id;
      m_phase <= 2;
    end else begin
      if (rsp_ready) begin
        m_rv    <= 1'b0;
        m_ops   <= m_ops + 8'd1;
        m_phase <= 0;
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    check("req0_ready", req0_ready, (m_phase == 0) && req0_valid && !m_w);
    check("req1_ready", req1_ready, (m_phase == 0) && req1_valid && m_w);
    check("rsp_valid",  rsp_valid,  m_rv);
    check("rsp_data",   rsp_data,   m_rd);
    check("rsp_id",     rsp_id,     m_rid);
    check("ops_done",   ops_done,   m_ops);
    check("rot_ain",    rot_ain,    m_ain);
    check("rot_shamt",  rot_shamt,  m_amt);
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) fail_now("sb_unexpected_rsp");
      else check("sb_rsp", {rsp_id, rsp_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic id, input logic [15:0] d, input logic [4:0] s,
                         input logic l, input logic v);
    if (id) begin
      req1_data = d; req1_shamt = s; req1_left = l; req1_valid = v;
    end else begin
      req0_data = d; req0_shamt = s; req0_left = l; req0_valid = v;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Accept wait, returning at the falling edge of the accepting cycle.
  task automatic wait_accept(input logic id, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // One operation with rsp_ready high, checked against hand-computed values.
  task automatic do_op(input logic id, input logic [15:0] d, input logic [4:0] s,
                       input logic l, input logic [15:0] exp_data, input logic [4:0] exp_rs);
    logic seen;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_req(id, d, s, l, 1'b1);
    wait_accept(id, seen);
    @(posedge clk); #1;
    set_req(id, d, s, l, 1'b0);
    if (!seen) begin
      fail_now("op_accept_timeout");
      return;
    end
    @(negedge clk);                       // EXEC cycle
    check("op_exec_rot_shamt", rot_shamt, exp_rs);
    check("op_exec_ready_low", id ? req1_ready : req0_ready, 1'b0);
    check("op_exec_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);                       // HOLD cycle, accept + 2
    check("op_rsp_valid", rsp_valid, 1'b1);
    check("op_rsp_data",  rsp_data,  exp_data);
    check("op_rsp_id",    rsp_id,    id);
    @(posedge clk); #1;
    @(negedge clk);
    check("op_rsp_released", rsp_valid, 1'b0);
  endtask

  task automatic contention();
    int g_id[4];
    int g_cyc[4];
    int n;
    int exp_ids[4] = '{0, 1, 0, 1};
    n = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_req(1'b0, 16'h1111, 5'd3, 1'b0, 1'b1);
    set_req(1'b1, 16'h8421, 5'd5, 1'b1, 1'b1);
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        g_id[n]  = req1_ready ? 1 : 0;
        g_cyc[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("cont_grant_count", n, 4);
    for (int k = 0; k < n; k++) begin
      check("cont_grant_id", g_id[k], exp_ids[k]);
      if (k > 0) check("cont_grant_gap", g_cyc[k] - g_cyc[k-1], 3);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic backpressure();
    logic seen;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1'b0, 16'h00F0, 5'd7, 1'b1, 1'b1);
    wait_accept(1'b0, seen);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    if (!seen) begin
      fail_now("bp_accept_timeout");
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail_now("bp_rsp_timeout");
      return;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      set_req(1'b1, 16'h5A5A, 5'd2, 1'b0, 1'b1);
      @(negedge clk);
      check("bp_rsp_valid",  rsp_valid,  1'b1);
      check("bp_rsp_data",   rsp_data,   16'h7800);
      check("bp_rsp_id",     rsp_id,     1'b0);
      check("bp_req0_ready", req0_ready, 1'b0);
      check("bp_req1_ready", req1_ready, 1'b0);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    check("bp_last_hold", rsp_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_released", rsp_valid, 1'b0);
  endtask

  task automatic reset_in_hold();
    logic seen;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(1'b1, 16'hF00F, 5'd4, 1'b0, 1'b1);
    wait_accept(1'b1, seen);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rh_valid_before", rsp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rh_valid_async",  rsp_valid, 1'b0);
    check("rh_ops_async",    ops_done,  8'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rh_no_rsp", rsp_valid, 1'b0);
    end
  endtask

  task automatic wrap_test();
    int n;
    n = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_req(1'b0, 16'h0001, 5'd1, 1'b0, 1'b1);
    for (int i = 0; i < 1200 && n < 256; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) n++;
    end
    #1 req0_valid = 1'b0;
    check("wrap_count", n, 256);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_ops_zero", ops_done, 8'd0);
    check("wrap_idle", rsp_valid, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #12;
    check("rst_rsp_valid", rsp_valid,  1'b0);
    check("rst_rsp_data",  rsp_data,   16'h0000);
    check("rst_rsp_id",    rsp_id,     1'b0);
    check("rst_ops_done",  ops_done,   8'd0);
    check("rst_rot_ain",   rot_ain,    16'h0000);
    check("rst_rot_shamt", rot_shamt,  5'd0);
    check("rst_ready0",    req0_ready, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_op(1'b0, 16'h8001, 5'd1,  1'b0, 16'hC000, 5'd1);
    check("first_ops_done", ops_done, 8'd1);
    do_op(1'b1, 16'h1234, 5'd4,  1'b1, 16'h2341, 5'd12);
    do_op(1'b0, 16'hABCD, 5'd16, 1'b0, 16'hABCD, 5'd0);
    do_op(1'b0, 16'hABCD, 5'd0,  1'b1, 16'hABCD, 5'd0);
    do_op(1'b1, 16'h0001, 5'd31, 1'b1, 16'h8000, 5'd1);
    do_op(1'b0, 16'h00F0, 5'd7,  1'b1, 16'h7800, 5'd9);
    do_op(1'b1, 16'hC3A5, 5'd20, 1'b0, 16'h5C3A, 5'd4);

    do_reset();
    contention();
    backpressure();
    reset_in_hold();
    do_reset();
    wrap_test();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
